mc_control_fsm: RTL and testbench

//  Multi-cycle sequencer for the RV32I core: a Moore FSM that steps one instruction over 3-5 cycles.

---
 rtl/mc_control_fsm_pkg.sv | 85 ++++++++
 rtl/mc_control_fsm_if.sv | 19 +
 rtl/mc_control_fsm_alu_decoder.sv | 33 +++
 rtl/mc_control_fsm.sv | 228 ++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle control FSM.
// Opcodes, ALU ops, mux selects and immediate formats.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALRWB,
    S_LUI,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALU_CLS_ADD,
    ALU_CLS_R,
    ALU_CLS_I,
    ALU_CLS_LUI
  } alu_cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ALU op = {funct7_5 qualifier, funct3}; LUI is a B passthrough
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RD1    = 2'b10;

  localparam logic [1:0] SRC_B_RD2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  function automatic logic [2:0] imm_sel(
    input logic [6:0] op
  );
    logic [2:0] s;
    s = IMM_I;
    unique case (op)
      OP_STORE:  s = IMM_S;
      OP_BRANCH: s = IMM_B;
      OP_LUI:    s = IMM_U;
      OP_JAL:    s = IMM_J;
      default:   s = IMM_I;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Unified memory port handshake between sequencer and memory.
// Request is held until the memory answers with ready.
interface mc_control_fsm_if;
  logic mem_req;
  logic mem_write;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    output mem_ready
  );
endinterface

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU op decode from state class and latched funct fields.
// funct7_5 only qualifies ADD/SUB (R) and SRL/SRA (R and I).
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control
);

  logic is_add_sub;
  logic is_shr;

  assign is_add_sub = (funct3 == 3'b000);
  assign is_shr     = (funct3 == 3'b101);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (cls)
      ALU_CLS_R:
        alu_control = {funct7_5 & (is_add_sub | is_shr),
                       funct3};
      ALU_CLS_I:
        alu_control = {funct7_5 & is_shr, funct3};
      ALU_CLS_LUI:
        alu_control = ALU_LUI;
      default:
        alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore sequencer for the multi-cycle RV32I core.
// One instruction per 3-5 states over a shared memory port.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  mc_control_fsm_if.master mem,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             branch_taken,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_src,
  output logic [3:0]       alu_control,
  output logic             illegal_instr
);

  localparam bit TO_EN = (FETCH_TIMEOUT != 0);
  localparam logic [7:0] TO_LAST =
    8'(FETCH_TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       timeout;
  alu_cls_t   alu_cls;
  logic       mem_req_d;
  logic       mem_write_d;
  logic [3:0] alu_op;

  logic is_load, is_store, is_r, is_i;
  logic is_br, is_jal, is_jalr, is_lui;

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_br    = (opcode == OP_BRANCH);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_lui   = (opcode == OP_LUI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != S_FETCH || mem.mem_ready)
        wait_cnt <= '0;
      else if (wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // wait_cnt holds the number of waits already seen
  assign timeout = TO_EN && (wait_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH:
        if (mem.mem_ready)
          state_nxt = S_DECODE;
        else if (timeout)
          state_nxt = S_TRAP;
      S_DECODE:
        unique case (1'b1)
          is_load, is_store: state_nxt = S_MEMADR;
          is_r:              state_nxt = S_EXECR;
          is_i:              state_nxt = S_EXECI;
          is_br:             state_nxt = S_BRANCH;
          is_jal:            state_nxt = S_JAL;
          is_jalr:           state_nxt = S_JALR;
          is_lui:            state_nxt = S_LUI;
          default:           state_nxt = S_TRAP;
        endcase
      S_MEMADR:
        state_nxt = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:
        if (mem.mem_ready)
          state_nxt = S_MEMWB;
      S_MEMWR:
        if (mem.mem_ready)
          state_nxt = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:
        state_nxt = S_ALUWB;
      S_JALR:
        state_nxt = S_JALRWB;
      S_MEMWB, S_ALUWB, S_BRANCH,
      S_JALRWB, S_LUI:
        state_nxt = S_FETCH;
      S_TRAP:
        state_nxt = S_TRAP;
      default:
        state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_d     = 1'b0;
    mem_write_d   = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RD2;
    result_src    = RES_ALUOUT;
    imm_src       = imm_sel(opcode);
    alu_cls       = ALU_CLS_ADD;
    illegal_instr = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req_d  = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        imm_src    = IMM_I;
        ir_write   = mem.mem_ready;
        pc_write   = mem.mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMRD: begin
        mem_req_d = 1'b1;
        adr_src   = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_req_d   = 1'b1;
        mem_write_d = 1'b1;
        adr_src     = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_RD2;
        alu_cls   = ALU_CLS_R;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        alu_cls   = ALU_CLS_I;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BRANCH: begin
        result_src = RES_ALUOUT;
        pc_write   = branch_taken;
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = SRC_A_RD1;
        alu_src_b  = SRC_B_IMM;
        result_src = RES_ALU;
        pc_write   = 1'b1;
      end
      S_JALRWB: begin
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        reg_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_b  = SRC_B_IMM;
        result_src = RES_ALU;
        reg_write  = 1'b1;
        alu_cls    = ALU_CLS_LUI;
      end
      S_TRAP: begin
        imm_src       = IMM_I;
        illegal_instr = 1'b1;
      end
      default: ;
    endcase
    // reset forces a quiet bus regardless of state
    if (reset) begin
      mem_req_d     = 1'b0;
      mem_write_d   = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_RD2;
      result_src    = RES_ALUOUT;
      imm_src       = IMM_I;
      alu_cls       = ALU_CLS_ADD;
      illegal_instr = 1'b0;
    end
  end

  mc_alu_decoder u_alu_dec (
    .cls         (alu_cls),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (alu_op)
  );

  assign alu_control   = alu_op;
  assign mem.mem_req   = mem_req_d;
  assign mem.mem_write = mem_write_d;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm.
// Reference: per-instruction micro-step table.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       branch_taken;

  mc_control_fsm_if mif();
  mc_control_fsm_if tif();

  logic       adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic       illegal_instr;

  logic       t_adr_src, t_ir_write, t_pc_write;
  logic       t_reg_write;
  logic [1:0] t_alu_src_a, t_alu_src_b, t_result_src;
  logic [2:0] t_imm_src;
  logic [3:0] t_alu_control;
  logic       t_illegal_instr;

  mc_control_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .mem           (mif.master),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .branch_taken  (branch_taken),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .imm_src       (imm_src),
    .alu_control   (alu_control),
    .illegal_instr (illegal_instr)
  );

  mc_control_fsm #(.FETCH_TIMEOUT(4)) dut_to (
    .clk           (clk),
    .reset         (reset),
    .mem           (tif.master),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .branch_taken  (branch_taken),
    .adr_src       (t_adr_src),
    .ir_write      (t_ir_write),
    .pc_write      (t_pc_write),
    .reg_write     (t_reg_write),
    .alu_src_a     (t_alu_src_a),
    .alu_src_b     (t_alu_src_b),
    .result_src    (t_result_src),
    .imm_src       (t_imm_src),
    .alu_control   (t_alu_control),
    .illegal_instr (t_illegal_instr)
  );

  logic [19:0] cw, tcw;
  assign cw = {mif.mem_req, mif.mem_write,
               adr_src, ir_write, pc_write,
               reg_write, alu_src_a, alu_src_b,
               result_src, imm_src, alu_control,
               illegal_instr};
  assign tcw = {tif.mem_req, tif.mem_write,
                t_adr_src, t_ir_write, t_pc_write,
                t_reg_write, t_alu_src_a, t_alu_src_b,
                t_result_src, t_imm_src, t_alu_control,
                t_illegal_instr};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [19:0] mk(
    input logic mreq, input logic mw,
    input logic adr,  input logic irw,
    input logic pcw,  input logic rw,
    input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] rs, input logic [2:0] imm,
    input logic [3:0] alu, input logic ill
  );
    return {mreq, mw, adr, irw, pcw, rw,
            a, b, rs, imm, alu, ill};
  endfunction

  function automatic logic [2:0] exp_imm(
    input logic [6:0] op
  );
    if (op == OP_STORE)  return 3'd1;
    if (op == OP_BRANCH) return 3'd2;
    if (op == OP_LUI)    return 3'd3;
    if (op == OP_JAL)    return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [3:0] exp_alu(
    input bit r, input logic [2:0] f3,
    input logic f7
  );
    if (r && f3 == 3'd0 && f7) return ALU_SUB;
    if (f3 == 3'd5 && f7)      return ALU_SRA;
    case (f3)
      3'd0: return ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  localparam logic [19:0] W_ZERO = 20'h0;
  localparam logic [19:0] W_TRAP = 20'h1;
  logic [19:0] w_fw, w_fg;

  typedef struct {
    logic [19:0] word;
    bit          waits;
    string       name;
  } step_t;

  task automatic tick(
    input string tag, input logic [19:0] exp,
    input bit to_dut
  );
    #1;
    check(tag, to_dut ? tcw : cw, exp);
    @(negedge clk);
  endtask

  task automatic run_instr(
    input logic [6:0] op, input logic [2:0] f3,
    input logic f7, input logic bt,
    input int fw, input int mw, input int abort_at
  );
    step_t plan[$];
    logic [2:0] im;
    logic [3:0] al;
    opcode = op; funct3 = f3;
    funct7_5 = f7; branch_taken = bt;
    for (int i = 0; i < fw; i++) begin
      mif.mem_ready = 1'b0;
      tick("fetch_wait", w_fw, 0);
    end
    mif.mem_ready = 1'b1;
    tick("fetch", w_fg, 0);
    im = exp_imm(op);
    al = exp_alu(op == OP_R, f3, f7);
    plan.push_back('{mk(0,0,0,0,0,0,2'b01,2'b01,
                        2'b00,im,ALU_ADD,0),
                     0, "decode"});
    if (op == OP_LOAD || op == OP_STORE)
      plan.push_back('{mk(0,0,0,0,0,0,2'b10,2'b01,
                          2'b00,im,ALU_ADD,0),
                       0, "memadr"});
    case (op)
      OP_LOAD: begin
        plan.push_back('{mk(1,0,1,0,0,0,2'b00,2'b00,
                            2'b00,im,ALU_ADD,0),
                         1, "memrd"});
        plan.push_back('{mk(0,0,0,0,0,1,2'b00,2'b00,
                            2'b01,im,ALU_ADD,0),
                         0, "memwb"});
      end
      OP_STORE:
        plan.push_back('{mk(1,1,1,0,0,0,2'b00,2'b00,
                            2'b00,im,ALU_ADD,0),
                         1, "memwr"});
      OP_R, OP_I: begin
        plan.push_back('{mk(0,0,0,0,0,0,2'b10,
                            (op == OP_R) ? 2'b00 : 2'b01,
                            2'b00,im,al,0),
                         0, "exec"});
        plan.push_back('{mk(0,0,0,0,0,1,2'b00,2'b00,
                            2'b00,im,ALU_ADD,0),
                         0, "aluwb"});
      end
      OP_BRANCH:
        plan.push_back('{mk(0,0,0,0,bt,0,2'b00,2'b00,
                            2'b00,im,ALU_ADD,0),
                         0, "branch"});
      OP_JAL: begin
        plan.push_back('{mk(0,0,0,0,1,0,2'b01,2'b10,
                            2'b00,im,ALU_ADD,0),
                         0, "jal"});
        plan.push_back('{mk(0,0,0,0,0,1,2'b00,2'b00,
                            2'b00,im,ALU_ADD,0),
                         0, "jal_wb"});
      end
      OP_JALR: begin
        plan.push_back('{mk(0,0,0,0,1,0,2'b10,2'b01,
                            2'b10,im,ALU_ADD,0),
                         0, "jalr"});
        plan.push_back('{mk(0,0,0,0,0,1,2'b01,2'b10,
                            2'b10,im,ALU_ADD,0),
                         0, "jalrwb"});
      end
      OP_LUI:
        plan.push_back('{mk(0,0,0,0,0,1,2'b00,2'b01,
                            2'b10,im,ALU_LUI,0),
                         0, "lui"});
      default: ;
    endcase
    foreach (plan[k]) begin
      if (!plan[k].waits) begin
        mif.mem_ready = 1'($urandom);
        tick(plan[k].name, plan[k].word, 0);
      end else begin
        for (int i = 0; i < mw; i++) begin
          if (i == abort_at) begin
            reset = 1'b1;
            mif.mem_ready = 1'b1;
            tick("abort_rst", W_ZERO, 0);
            reset = 1'b0;
            mif.mem_ready = 1'b0;
            tick("abort_fetch", w_fw, 0);
            return;
          end
          mif.mem_ready = 1'b0;
          tick(plan[k].name, plan[k].word, 0);
        end
        mif.mem_ready = 1'b1;
        tick(plan[k].name, plan[k].word, 0);
      end
    end
  endtask

  logic [6:0] ops [8];

  initial begin
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
    w_fw = mk(1,0,0,0,0,0,2'b00,2'b10,2'b10,
              3'd0,ALU_ADD,0);
    w_fg = mk(1,0,0,1,1,0,2'b00,2'b10,2'b10,
              3'd0,ALU_ADD,0);
    reset = 1'b1;
    mif.mem_ready = 1'b1;
    tif.mem_ready = 1'b0;
    opcode = OP_I; funct3 = 3'd0;
    funct7_5 = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_to", tcw, W_ZERO);
      tick("rst", W_ZERO, 0);
    end
    reset = 1'b0;
    run_instr(OP_I, 3'd0, 1'b0, 1'b0, 0, 0, -1);
    run_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 0, 3, -1);
    run_instr(OP_BRANCH, 3'd0, 1'b0, 1'b1, 0, 0, -1);
    run_instr(OP_BRANCH, 3'd0, 1'b0, 1'b0, 1, 0, -1);
    run_instr(OP_R, 3'd0, 1'b1, 1'b0, 0, 0, -1);
    run_instr(OP_R, 3'd0, 1'b0, 1'b0, 0, 0, -1);
    run_instr(OP_I, 3'd5, 1'b1, 1'b0, 0, 0, -1);
    run_instr(OP_I, 3'd5, 1'b0, 1'b0, 0, 0, -1);
    for (int n = 0; n < 80; n++)
      run_instr(ops[$urandom_range(0, 7)],
                3'($urandom), 1'($urandom),
                1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 3), -1);
    run_instr(OP_STORE, 3'd2, 1'b0, 1'b0, 0, 4, 2);
    run_instr(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, -1);
    for (int i = 0; i < 20; i++) begin
      mif.mem_ready = 1'($urandom);
      tick("trap", W_TRAP, 0);
    end
    reset = 1'b1;
    tick("trap_rst", W_ZERO, 0);
    reset = 1'b0;
    mif.mem_ready = 1'b0;
    tick("trap_exit", w_fw, 0);
    run_instr(OP_JAL, 3'd0, 1'b0, 1'b0, 0, 0, -1);
    reset = 1'b1;
    tick("to_rst", W_ZERO, 1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      tick("to_wait", w_fw, 1);
    tick("to_trap", W_TRAP, 1);
    tick("to_hold", W_TRAP, 1);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
